// File: rtl/mul_pkg.sv
// Shared definitions for the iterative Booth multiplier: op encoding,
// controller states and the radix-4 iteration count helper.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Radix-4 steps needed for a width-bit operand extended by two guard bits.
    function automatic int iter_count(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/gen_partial_product.sv
// Radix-4 Booth partial-product generator.
// o_pp carries the selected multiple (one's complement when negative) with its
// top bit inverted; the signed value is {~o_pp[W], o_pp[W-1:0]} + o_sign.
module gen_partial_product #(
    parameter int WIDTH = 66
) (
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [2:0]       i_triplet,
    output logic [WIDTH:0]   o_pp,
    output logic             o_sign
);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_mag;
    logic [WIDTH:0] w_val;
    logic           w_neg;

    assign w_ext = {i_mcand[WIDTH-1], i_mcand};

    // Decode the triplet into a multiple of {0, 1, 2} and a negate flag.
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (i_triplet)
            3'b001, 3'b010: w_mag = w_ext;
            3'b011:         w_mag = w_ext << 1;
            3'b100: begin
                w_mag = w_ext << 1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = w_ext;
                w_neg = 1'b1;
            end
            default: begin
                w_mag = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    assign w_val  = w_neg ? ~w_mag : w_mag;
    assign o_pp   = {~w_val[WIDTH], w_val[WIDTH-1:0]};
    assign o_sign = w_neg;

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// One Booth digit per BUSY cycle; the accumulator shifts right by two each step
// so every partial product is added at the same fixed position.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a request
//   BUSY  | one Booth iteration per clock
//   DONE  | out_valid high, result held until out_ready
module booth_mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             is_word,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int E          = WIDTH + 2;
    localparam int ITERS      = iter_count(WIDTH);
    localparam int WW         = (WIDTH >= 32) ? 32 : WIDTH;
    localparam int WORD_ITERS = iter_count(WW);
    // A word op runs fewer steps, so its product ends up left of bit 0 by
    // two bits for every step it skipped.
    localparam int WSH        = 2 * (ITERS - WORD_ITERS);
    localparam int CW         = $clog2(ITERS + 1);

    state_t          r_state;
    logic [E-1:0]    r_mcand;
    logic [E-1:0]    r_mplr;
    logic            r_prev;
    logic [2*E-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic            r_word;

    logic [E-1:0]    w_mcand_ext;
    logic [E-1:0]    w_mplr_ext;
    logic [E:0]      w_pp;
    logic            w_pp_sign;
    logic [E+1:0]    w_pp_ext;
    logic [E+1:0]    w_upper;
    logic [2*E-1:0]  w_acc_next;

    // Operand extension selected by op / is_word at the accept edge.
    always_comb begin
        w_mcand_ext = E'(src1);
        w_mplr_ext  = E'(src2);
        if (is_word) begin
            w_mcand_ext = E'($signed(src1[WW-1:0]));
            w_mplr_ext  = E'($signed(src2[WW-1:0]));
        end else begin
            if (op == MUL_OP_MULH || op == MUL_OP_MULHSU)
                w_mcand_ext = E'($signed(src1));
            if (op == MUL_OP_MULH)
                w_mplr_ext = E'($signed(src2));
        end
    end

    gen_partial_product #(
        .WIDTH (E)
    ) u_gen_pp (
        .i_mcand   (r_mcand),
        .i_triplet ({r_mplr[1:0], r_prev}),
        .o_pp      (w_pp),
        .o_sign    (w_pp_sign)
    );

    // Add the partial product to the upper half, then shift right by two.
    always_comb begin
        w_pp_ext   = {{2{~w_pp[E]}}, w_pp[E-1:0]};
        w_upper    = {{2{r_acc[2*E-1]}}, r_acc[2*E-1:E]} + w_pp_ext
                     + (E+2)'(w_pp_sign);
        w_acc_next = {w_upper, r_acc[E-1:2]};
    end

    // Controller, operand registers, accumulator and iteration down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_prev  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_word  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= w_mcand_ext;
                        r_mplr  <= w_mplr_ext;
                        r_prev  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= is_word ? CW'(WORD_ITERS) : CW'(ITERS);
                        r_op    <= op;
                        r_word  <= is_word;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc  <= w_acc_next;
                    r_mplr <= r_mplr >> 2;
                    r_prev <= r_mplr[1];
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // Result slice straight from the accumulator, which is frozen in DONE.
    always_comb begin
        if (r_word)
            result = WIDTH'($signed(r_acc[WSH +: WW]));
        else if (r_op == MUL_OP_MUL)
            result = r_acc[WIDTH-1:0];
        else
            result = r_acc[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench for booth_mul_iter: a driver issues requests and queues the
// expected result and latency; a monitor checks outputs as the DUT presents them.
module tb_booth_mul_iter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        is_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rnd_on   = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    booth_mul_iter #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: full-precision product of the extended operands.
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [131:0] sa;
        logic signed [131:0] sb;
        logic signed [131:0] p;
        if (w) begin
            sa = {{100{a[31]}}, a[31:0]};
            sb = {{100{b[31]}}, b[31:0]};
            p  = sa * sb;
            return {{32{p[31]}}, p[31:0]};
        end
        sa = (o == 2'b01 || o == 2'b10) ? {{68{a[63]}}, a} : {68'd0, a};
        sb = (o == 2'b01) ? {{68{b[63]}}, b} : {68'd0, b};
        p  = sa * sb;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'd1;
            4:       return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Wait for in_ready, present one request for one cycle; optionally record
    // the expected result/latency for the monitor.
    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input bit track);
        bit got = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("issue_wait_in_ready", 64'(in_ready), 64'd1);
            return;
        end
        op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (track) begin
            exp_q.push_back(exp);
            lat_q.push_back(w ? 17 : 33);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_out_valid(output bit busy_rdy_seen);
        bit seen = 0;
        busy_rdy_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (in_ready) busy_rdy_seen = 1;
        end
        if (!seen) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // Monitor: latency on rising out_valid, hold stability under backpressure,
    // result comparison at each handshake.
    logic        m_prev_valid = 1'b0;
    logic        m_prev_hold  = 1'b0;
    logic [63:0] m_prev_res   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_valid <= 1'b0;
            m_prev_hold  <= 1'b0;
        end else begin
            if (out_valid && !m_prev_valid) begin
                if (lat_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    int l;
                    int a;
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    chk("latency", 64'(cyc - a), 64'(l));
                end
            end
            if (m_prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", result, m_prev_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_result", 64'(out_valid), 64'd0);
                else
                    chk("result", result, exp_q.pop_front());
            end
            m_prev_hold  <= out_valid && !out_ready && !flush;
            m_prev_res   <= result;
            m_prev_valid <= out_valid;
        end
    end

    always begin
        @(posedge clk); #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        logic [1:0]  ro;
        logic        rw;
        logic [63:0] ra;
        logic [63:0] rb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; is_word = 1'b0;
        src1 = '0; src2 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // MUL 3*5 with latency and in_ready checked across BUSY
        issue(2'b00, 1'b0, 64'd3, 64'd5, 64'd15, 1);
        wait_out_valid(bad);
        chk("busy_in_ready_low", 64'(bad), 64'd0);

        issue(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 1);
        issue(2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 1);
        issue(2'b10, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        issue(2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1);

        // Backpressure with a competing request held on in_valid
        issue(2'b00, 1'b0, 64'd1234, 64'd1000, 64'd1234000, 1);
        out_ready = 1'b0;
        wait_out_valid(bad);
        op = 2'b00; is_word = 1'b0; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (in_ready) bad = 1;
        end
        chk("bp_in_ready_low", 64'(bad), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        issue(2'b01, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1);

        // Flush mid-BUSY, then a full-latency op
        issue(2'b00, 1'b0, 64'd11, 64'd13, 64'd0, 0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        issue(2'b00, 1'b0, 64'd7, -64'sd6, -64'sd42, 1);

        // flush together with in_valid in IDLE: not accepted
        issue(2'b00, 1'b0, 64'd2, 64'd2, 64'd4, 1);
        for (int k = 0; k < 60 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        op = 2'b00; is_word = 1'b0; src1 = 64'd5; src2 = 64'd5;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_in_valid_not_taken", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);

        // Asynchronous reset mid-BUSY
        issue(2'b11, 1'b0, '1, '1, 64'd0, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // Random ops against the reference model with random backpressure
        rnd_on = 1;
        for (int n = 0; n < 1200; n++) begin
            ro = 2'($urandom_range(0, 3));
            rw = (ro == 2'b00) && ($urandom_range(0, 2) == 0);
            ra = pick_operand();
            rb = pick_operand();
            issue(ro, rw, ra, rb, ref_mul(ro, rw, ra, rb), 1);
        end

        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        rnd_on = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
